servo_scheduler: RTL and testbench

SERVO_SCHEDULER -- requirements
Module: servo_scheduler

---
 rtl/servo_scheduler.sv | 153 +++++++++++++++
 tb/tb_servo_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_scheduler.sv
// rtl/servo_scheduler.sv - moves one of four servos at a time toward a clamped goal duty
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req[3:0]     per-servo move request (0 arm, 1 left, 2 middle, 3 right), held until ack
//   target       four packed DUTY_W requested duties, servo n at [n*DUTY_W +: DUTY_W]
//   period_done  per-servo PWM end-of-period strobe
//   servo_duty   four packed DUTY_W duty commands, same packing as target
//   ack[3:0]     one-cycle completion pulse to the granted servo
//   busy         high whenever the scheduler is not idle
//   active[1:0]  index of the granted servo
// Build option: SERVO_RAMP_EN defined -> ramp by STEP per period; undefined -> jump to goal in one update.
module servo_scheduler #(
  parameter int DUTY_W         = 21,
  parameter int STEP           = 10000,
  parameter int MIN_DUTY       = 100000,
  parameter int MAX_DUTY       = 200000,
  parameter int HOME_DUTY      = 150000,
  parameter int SETTLE_PERIODS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DUTY_W-1:0] target,
  input  logic [3:0]          period_done,
  output logic [4*DUTY_W-1:0] servo_duty,
  output logic [3:0]          ack,
  output logic                busy,
  output logic [1:0]          active
);

`ifdef SERVO_RAMP_EN
  localparam int stepSize = STEP;
`else
  // A step at least as wide as the clamp window always lands on goal in one update.
  localparam int stepSize = (STEP > MAX_DUTY - MIN_DUTY) ? STEP : (MAX_DUTY - MIN_DUTY);
`endif

  localparam logic [DUTY_W-1:0] stepD   = DUTY_W'(stepSize);
  localparam logic [DUTY_W-1:0] minD    = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0] maxD    = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] homeD   = DUTY_W'(HOME_DUTY);
  localparam logic [7:0]        settleD = 8'(SETTLE_PERIODS);

  typedef enum logic [2:0] {IDLE, LOAD, RAMP, SETTLE, DONE} stateT;

  stateT             state, nextState;
  logic [1:0]        activeIdx, rrPtr, grantIdx;
  logic              grantFound;
  logic [DUTY_W-1:0] duty [4];
  logic [DUTY_W-1:0] tgt [4];
  logic [DUTY_W-1:0] goal, curDuty, nextDuty, clampedTarget;
  logic [7:0]        settleCnt;
  logic              pdActive, settleDone;

  for (genvar g = 0; g < 4; g++) begin : gPack
    assign tgt[g] = target[g*DUTY_W +: DUTY_W];
    assign servo_duty[g*DUTY_W +: DUTY_W] = duty[g];
  end

  assign curDuty  = duty[activeIdx];
  assign pdActive = period_done[activeIdx];
  assign active   = activeIdx;

  // Round-robin search starting at the servo after the last grant.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = rrPtr;
    for (int i = 0; i < 4; i++) begin
      if (!grantFound && req[rrPtr + 2'(i)]) begin
        grantFound = 1'b1;
        grantIdx   = rrPtr + 2'(i);
      end
    end
  end

  always_comb begin
    clampedTarget = tgt[activeIdx];
    if (tgt[activeIdx] < minD)
      clampedTarget = minD;
    else if (tgt[activeIdx] > maxD)
      clampedTarget = maxD;
  end

  // Goal and current duty both sit inside the clamp window, so stepping toward
  // goal can neither wrap nor leave the window.
  always_comb begin
    nextDuty = curDuty;
    if (goal > curDuty)
      nextDuty = (goal - curDuty <= stepD) ? goal : curDuty + stepD;
    else if (curDuty > goal)
      nextDuty = (curDuty - goal <= stepD) ? goal : curDuty - stepD;
  end

  assign settleDone = (settleCnt >= settleD) || (pdActive && (settleCnt + 8'd1 >= settleD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState = state;
    ack       = 4'b0000;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (grantFound) nextState = LOAD;
      LOAD:    nextState = RAMP;
      RAMP:    if (curDuty == goal) nextState = SETTLE;
      SETTLE:  if (settleDone) nextState = DONE;
      DONE: begin
        ack       = 4'b0001 << activeIdx;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 4; n++) duty[n] <= homeD;
      activeIdx <= 2'd0;
      rrPtr     <= 2'd0;
      goal      <= homeD;
      settleCnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grantFound) begin
            activeIdx <= grantIdx;
            rrPtr     <= grantIdx + 2'd1;
          end
        end
        LOAD: begin
          goal      <= clampedTarget;
          settleCnt <= 8'd0;
        end
        // The new duty becomes visible the cycle after the period strobe, i.e.
        // at the start of the next PWM period.
        RAMP: begin
          if (pdActive && (curDuty != goal)) duty[activeIdx] <= nextDuty;
        end
        SETTLE: begin
          if (pdActive) settleCnt <= settleCnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_scheduler.sv
// tb/tb_servo_scheduler.sv - scoreboard bench for servo_scheduler
module tb_servo_scheduler;
  localparam int W = 21;

`ifdef SERVO_RAMP_EN
  localparam int nFar  = 7;  // five ramp updates plus two settle periods
  localparam int nNear = 5;  // three ramp updates plus two settle periods
`else
  localparam int nFar  = 3;
  localparam int nNear = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] target;
  logic [3:0]     period_done;
  logic [4*W-1:0] servo_duty;
  logic [3:0]     ack;
  logic           busy;
  logic [1:0]     active;

  logic [W-1:0]   tgtArr [4];
  logic [W-1:0]   dutyOf [4];
  logic [W-1:0]   prevDuty [4];

  assign target    = {tgtArr[3], tgtArr[2], tgtArr[1], tgtArr[0]};
  assign dutyOf[0] = servo_duty[W-1:0];
  assign dutyOf[1] = servo_duty[2*W-1:W];
  assign dutyOf[2] = servo_duty[3*W-1:2*W];
  assign dutyOf[3] = servo_duty[4*W-1:3*W];

  servo_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .period_done(period_done),
    .servo_duty(servo_duty), .ack(ack), .busy(busy), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         isAck;
    logic [1:0]   servo;
    logic [W-1:0] value;
  } evT;

  evT   sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic monEn = 1'b0;
  logic countIdle = 1'b0;
  int   idleCycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expDuty(input logic [1:0] s, input int v);
    evT e;
    e.isAck = 1'b0;
    e.servo = s;
    e.value = v[W-1:0];
    sb.push_back(e);
  endtask

  task automatic expAck(input logic [1:0] s);
    evT e;
    e.isAck = 1'b1;
    e.servo = s;
    e.value = '0;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] s);
    repeat (4) @(posedge clk);
    #1 period_done[s] = 1'b1;
    @(posedge clk);
    #1 period_done = 4'b0000;
  endtask

  task automatic waitAck(input logic [1:0] s, input bit clearReq);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (ack[s]) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL ack timeout: servo %0d got no ack within 60 cycles", s);
    end
    #1 if (clearReq) req[s] = 1'b0;
  endtask

  task automatic runMove(input logic [1:0] s, input int n);
    repeat (n) pulse(s);
    waitAck(s, 1'b1);
  endtask

  // Monitor: every duty change or ack pops the next expected event.
  initial begin
    evT e;
    logic [1:0] s;
    forever begin
      @(negedge clk);
      if (countIdle && !busy) idleCycles++;
      if (monEn) begin
        for (int i = 0; i < 4; i++) begin
          s = 2'(i);
          if (dutyOf[s] !== prevDuty[s]) begin
            if (sb.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected duty change: servo %0d now %0d", s, dutyOf[s]);
            end else begin
              e = sb.pop_front();
              check("duty event kind/servo", 32'({1'b0, s}), 32'({e.isAck, e.servo}));
              check("duty value", 32'(dutyOf[s]), 32'(e.value));
            end
            prevDuty[s] = dutyOf[s];
          end
        end
        if (ack !== 4'b0000) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected ack: got %b, expected none", ack);
          end else begin
            e = sb.pop_front();
            check("ack vector", 32'(ack), e.isAck ? 32'(4'b0001 << e.servo) : 32'd0);
            check("active at ack", 32'(active), 32'(e.servo));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    period_done = 4'b0000;
    for (int i = 0; i < 4; i++) tgtArr[i] = W'(150000);
    #2 rst = 1'b0;

    // Reset state, while held and after release.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check("duty in reset", 32'(dutyOf[2'(i)]), 32'd150000);
    check("busy in reset", 32'(busy), 32'd0);
    check("ack in reset", 32'(ack), 32'd0);
    check("active in reset", 32'(active), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check("duty after reset", 32'(dutyOf[2'(i)]), 32'd150000);
    check("busy after reset", 32'(busy), 32'd0);
    check("ack after reset", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) prevDuty[i] = dutyOf[2'(i)];
    monEn = 1'b1;

    // Arm to 200000; target change after LOAD and a strobe on left are ignored.
    tgtArr[0] = W'(200000);
`ifdef SERVO_RAMP_EN
    expDuty(0, 160000); expDuty(0, 170000); expDuty(0, 180000);
    expDuty(0, 190000); expDuty(0, 200000);
`else
    expDuty(0, 200000);
`endif
    expAck(0);
    req[0] = 1'b1;
    pulse(0);
    tgtArr[0] = W'(100000);
    pulse(1);
    repeat (nFar - 1) pulse(0);
    waitAck(0, 1'b1);

    // Left to 50000 clamps at 100000; req dropped mid-move still completes.
    tgtArr[1] = W'(50000);
`ifdef SERVO_RAMP_EN
    expDuty(1, 140000); expDuty(1, 130000); expDuty(1, 120000);
    expDuty(1, 110000); expDuty(1, 100000);
`else
    expDuty(1, 100000);
`endif
    expAck(1);
    req[1] = 1'b1;
    pulse(1);
    req[1] = 1'b0;
    repeat (nFar - 1) pulse(1);
    waitAck(1, 1'b1);

    // Middle toward 200000, reset mid-move: no ack, duties return home.
    tgtArr[2] = W'(200000);
    req[2] = 1'b1;
`ifdef SERVO_RAMP_EN
    expDuty(2, 160000); expDuty(2, 170000); expDuty(2, 180000);
    repeat (3) pulse(2);
`else
    expDuty(2, 200000);
    pulse(2);
`endif
    expDuty(0, 150000); expDuty(1, 150000); expDuty(2, 150000);
    @(negedge clk);
    #1 rst = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    check("busy during mid-move reset", 32'(busy), 32'd0);
    check("ack during mid-move reset", 32'(ack), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("busy after mid-move reset", 32'(busy), 32'd0);

    // Middle granted normally after the abandoned move.
    tgtArr[2] = W'(120000);
`ifdef SERVO_RAMP_EN
    expDuty(2, 140000); expDuty(2, 130000); expDuty(2, 120000);
`else
    expDuty(2, 120000);
`endif
    expAck(2);
    req[2] = 1'b1;
    runMove(2, nNear);

    // Reset so the round-robin pointer is back at arm.
    repeat (3) @(negedge clk);
    expDuty(2, 150000);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All four requesting: served arm, left, middle, right with one idle cycle between.
    for (int i = 0; i < 4; i++) begin
      tgtArr[i] = W'(120000);
`ifdef SERVO_RAMP_EN
      expDuty(2'(i), 140000); expDuty(2'(i), 130000); expDuty(2'(i), 120000);
`else
      expDuty(2'(i), 120000);
`endif
      expAck(2'(i));
    end
    req = 4'b1111;
    for (int c = 0; c < 20 && !busy; c++) @(negedge clk);
    countIdle = 1'b1;
    for (int i = 0; i < 4; i++) runMove(2'(i), nNear);
    countIdle = 1'b0;
    check("idle cycles between grants", 32'(idleCycles), 32'd3);

    // Arm already at goal: no duty change; req held one cycle past ack is granted again.
    repeat (3) @(negedge clk);
    expAck(0);
    expAck(0);
    req[0] = 1'b1;
    repeat (2) pulse(0);
    waitAck(0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (2) pulse(0);
    waitAck(0, 1'b1);

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    check("busy at end", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
